// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arbiter
//  Purpose  : Arbitrates an instruction-cache port and a data-cache port onto
//             a single memory request/response channel. At most one memory
//             transaction is outstanding; its owner receives a one-cycle
//             completion pulse and the returned read word.
//
//  Ports    : clk, reset            - single clock, synchronous active-high reset
//             inst_cache_*          - instruction-cache read request / result
//             data_cache_*          - data-cache read/write request / result
//             mem_req/wr/addr/...   - memory-side request (held until addr_ok)
//             mem_addr_ok/data_ok   - memory-side accept / completion strobes
//             mem_rdata             - memory-side read data
//
//  Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,

    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    input  logic [3:0]  data_cache_wstrb,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_owner_data;   // 1: data port owns the transaction
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rbuf;         // shared read buffer shown on both rdata ports

    logic [1:0]  w_state;
    logic        w_owner_data;
    logic        w_wr;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_rbuf;
    logic        w_grant_data;

    // Data port wins when it is the only requester or when it has priority.
    assign w_grant_data = data_cache_req && ((DATA_FIRST != 0) || !inst_cache_req);

    always_comb begin
        w_state      = r_state;
        w_owner_data = r_owner_data;
        w_wr         = r_wr;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_wstrb      = r_wstrb;
        w_rbuf       = r_rbuf;
        case (r_state)
            S_IDLE: begin
                if (inst_cache_req || data_cache_req) begin
                    w_owner_data = w_grant_data;
                    if (w_grant_data) begin
                        w_wr    = data_cache_wr;
                        w_addr  = data_cache_addr;
                        w_wdata = data_cache_wdata;
                        w_wstrb = data_cache_wstrb;
                    end else begin
                        // Instruction fetches are plain reads.
                        w_wr    = 1'b0;
                        w_addr  = inst_cache_addr;
                        w_wdata = 32'd0;
                        w_wstrb = 4'd0;
                    end
                    w_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mem_addr_ok) begin
                    w_state = S_DATA;
                end
            end
            S_DATA: begin
                if (mem_data_ok) begin
                    if (!r_wr) begin
                        w_rbuf = mem_rdata;
                    end
                    w_state = S_DONE;
                end
            end
            // Requests are deliberately not sampled here so a requester that
            // drops req on seeing dok is never granted a second time.
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_rbuf       <= 32'd0;
        end else begin
            r_state      <= w_state;
            r_owner_data <= w_owner_data;
            r_wr         <= w_wr;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_wstrb      <= w_wstrb;
            r_rbuf       <= w_rbuf;
        end
    end

    // Every output is a register or a decode of the state register only.
    assign mem_req          = (r_state == S_ADDR);
    assign mem_wr           = r_wr;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign mem_wstrb        = r_wstrb;
    assign inst_cache_dok   = (r_state == S_DONE) && !r_owner_data;
    assign data_cache_dok   = (r_state == S_DONE) &&  r_owner_data;
    assign inst_cache_rdata = r_rbuf;
    assign data_cache_rdata = r_rbuf;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_arbiter
//  Purpose  : Self-checking bench for cache_arbiter: directed scenarios with
//             literal expectations, then randomized requesters and a
//             randomized memory slave compared against a transaction-level
//             model every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int DATA_FIRST = 1;

    logic        clk;
    logic        reset;
    logic        inst_cache_req;
    logic [31:0] inst_cache_addr;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    logic        data_cache_req;
    logic        data_cache_wr;
    logic [31:0] data_cache_addr;
    logic [31:0] data_cache_wdata;
    logic [3:0]  data_cache_wstrb;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    cache_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_cache_req   (inst_cache_req),
        .inst_cache_addr  (inst_cache_addr),
        .inst_cache_rdata (inst_cache_rdata),
        .inst_cache_dok   (inst_cache_dok),
        .data_cache_req   (data_cache_req),
        .data_cache_wr    (data_cache_wr),
        .data_cache_addr  (data_cache_addr),
        .data_cache_wdata (data_cache_wdata),
        .data_cache_wstrb (data_cache_wstrb),
        .data_cache_rdata (data_cache_rdata),
        .data_cache_dok   (data_cache_dok),
        .mem_req          (mem_req),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_addr_ok      (mem_addr_ok),
        .mem_data_ok      (mem_data_ok),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_dok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_BFC0;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- stimulus control (written by main only) ----------------
    logic        rand_mode   = 1'b0;
    logic        rand_waits  = 1'b0;
    logic        inj_data_ok = 1'b0;
    int          cfg_aw      = 0;
    int          cfg_dw      = 0;
    logic        dir_inst_req   = 1'b0;
    logic [31:0] dir_inst_addr  = '0;
    logic        dir_data_req   = 1'b0;
    logic        dir_data_wr    = 1'b0;
    logic [31:0] dir_data_addr  = '0;
    logic [31:0] dir_data_wdata = '0;
    logic [3:0]  dir_data_wstrb = '0;

    // ---------------- requesters (sole writer of request inputs) -------------
    initial begin
        inst_cache_req = 0; inst_cache_addr = 0;
        data_cache_req = 0; data_cache_wr = 0; data_cache_addr = 0;
        data_cache_wdata = 0; data_cache_wstrb = 0;
    end

    always @(negedge clk) begin
        if (!rand_mode) begin
            inst_cache_req   = dir_inst_req;
            inst_cache_addr  = dir_inst_addr;
            data_cache_req   = dir_data_req;
            data_cache_wr    = dir_data_wr;
            data_cache_addr  = dir_data_addr;
            data_cache_wdata = dir_data_wdata;
            data_cache_wstrb = dir_data_wstrb;
        end else begin
            if (inst_cache_req) begin
                if (inst_cache_dok || $urandom_range(0, 63) == 0) inst_cache_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                inst_cache_req  = 1'b1;
                inst_cache_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (data_cache_req) begin
                if (data_cache_dok || $urandom_range(0, 63) == 0) data_cache_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                data_cache_req   = 1'b1;
                data_cache_wr    = 1'($urandom_range(0, 1));
                data_cache_addr  = $urandom() & 32'hFFFF_FFFC;
                data_cache_wdata = $urandom();
                data_cache_wstrb = 4'($urandom_range(0, 15));
            end
        end
    end

    // ---------------- memory slave (sole writer of mem_* inputs) -------------
    logic        s_phase = 1'b0;    // 0: waiting for request, 1: data phase
    int          s_wait  = 0;
    int          s_ra    = 0;
    int          s_rd    = 0;
    logic [31:0] s_addr  = '0;

    initial begin
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    end

    always @(negedge clk) begin
        int lim_a;
        int lim_d;
        lim_a = rand_waits ? s_ra : cfg_aw;
        lim_d = rand_waits ? s_rd : cfg_dw;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom();
        if (reset) begin
            s_phase = 1'b0;
            s_wait  = 0;
        end else if (!s_phase) begin
            if (mem_req) begin
                if (s_wait >= lim_a) begin
                    mem_addr_ok = 1'b1;
                    s_addr  = mem_addr;
                    s_phase = 1'b1;
                    s_wait  = 0;
                end else begin
                    s_wait++;
                end
            end else if (rand_waits && $urandom_range(0, 7) == 0) begin
                mem_addr_ok = 1'b1;     // stray accept outside a request
            end
            if (rand_waits && $urandom_range(0, 7) == 0) mem_data_ok = 1'b1;  // stray completion
        end else begin
            if (s_wait >= lim_d) begin
                mem_data_ok = 1'b1;
                mem_rdata   = mem_word(s_addr);
                s_phase = 1'b0;
                s_wait  = 0;
                s_ra    = $urandom_range(0, 3);
                s_rd    = $urandom_range(0, 3);
            end else begin
                s_wait++;
                if (rand_waits && $urandom_range(0, 7) == 0) mem_addr_ok = 1'b1;
            end
        end
        if (inj_data_ok) mem_data_ok = 1'b1;
    end

    // ---------------- transaction-level reference model ----------------------
    logic        m_busy = 0, m_adone = 0, m_ddone = 0, m_owner = 0, m_wr = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rbuf = 0;
    logic [3:0]  m_wstrb = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_adone = 0; m_ddone = 0; m_owner = 0; m_rbuf = 0;
        end else if (!m_busy) begin
            if (inst_cache_req || data_cache_req) begin
                m_owner = data_cache_req && (DATA_FIRST != 0 || !inst_cache_req);
                m_wr    = m_owner ? data_cache_wr    : 1'b0;
                m_addr  = m_owner ? data_cache_addr  : inst_cache_addr;
                m_wdata = m_owner ? data_cache_wdata : 32'd0;
                m_wstrb = m_owner ? data_cache_wstrb : 4'd0;
                m_busy = 1; m_adone = 0; m_ddone = 0;
            end
        end else if (m_ddone) begin
            m_busy = 0;              // completion cycle; no new grant here
        end else if (!m_adone) begin
            if (mem_addr_ok) m_adone = 1;
        end else if (mem_data_ok) begin
            m_ddone = 1;
            if (!m_wr) m_rbuf = mem_rdata;
        end
    end

    // ---------------- per-cycle compare ---------------------------------------
    always begin
        logic exp_req;
        @(posedge clk);
        #1;
        exp_req = m_busy && !m_adone;
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) begin
            chk("mem_wr", 32'(mem_wr), 32'(m_wr));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("inst_dok", 32'(inst_cache_dok), 32'(m_busy && m_ddone && !m_owner));
        chk("data_dok", 32'(data_cache_dok), 32'(m_busy && m_ddone && m_owner));
        chk("inst_rdata", inst_cache_rdata, m_rbuf);
        chk("data_rdata", data_cache_rdata, m_rbuf);
        if (inst_cache_dok || data_cache_dok) n_dok++;
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        int dok_start;
        reset = 1'b1;
        tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_inst_dok", 32'(inst_cache_dok), 0);
        chk("rst_data_dok", 32'(data_cache_dok), 0);
        chk("rst_rdata", data_cache_rdata, 0);
        tick();
        reset = 1'b0;

        // Instruction read, zero-wait memory.
        dir_inst_addr = 32'hBFC0_0000; dir_inst_req = 1;
        tick();
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("t1_mem_wr", 32'(mem_wr), 0);
        chk("t1_dok_t1", 32'(inst_cache_dok), 0);
        tick();
        chk("t1_dok_t2", 32'(inst_cache_dok), 0);
        chk("t1_req_t2", 32'(mem_req), 0);
        tick();
        chk("t1_dok_t3", 32'(inst_cache_dok), 1);
        chk("t1_rdata", inst_cache_rdata, 32'h3C08_BFC0);
        chk("t1_ddok_t3", 32'(data_cache_dok), 0);
        dir_inst_req = 0;
        tick();
        chk("t1_dok_t4", 32'(inst_cache_dok), 0);
        tick();
        chk("t1_noreq_t5", 32'(mem_req), 0);

        // Data write, zero-wait memory.
        dir_data_wr = 1; dir_data_addr = 32'h8000_1000;
        dir_data_wdata = 32'hDEAD_BEEF; dir_data_wstrb = 4'hF; dir_data_req = 1;
        tick();
        chk("t2_mem_req", 32'(mem_req), 1);
        chk("t2_mem_wr", 32'(mem_wr), 1);
        chk("t2_mem_addr", mem_addr, 32'h8000_1000);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_wstrb", 32'(mem_wstrb), 32'hF);
        tick();
        chk("t2_dok_t2", 32'(data_cache_dok), 0);
        tick();
        chk("t2_dok_t3", 32'(data_cache_dok), 1);
        chk("t2_idok_t3", 32'(inst_cache_dok), 0);
        chk("t2_rdata_kept", data_cache_rdata, 32'h3C08_BFC0);
        dir_data_req = 0;
        tick();
        chk("t2_dok_t4", 32'(data_cache_dok), 0);

        // Simultaneous requests: data first, instruction two cycles after dok.
        dir_data_wr = 0; dir_data_addr = 32'h8000_2000; dir_data_wstrb = 0; dir_data_req = 1;
        dir_inst_addr = 32'hBFC0_0010; dir_inst_req = 1;
        tick();
        chk("t3_addr_data", mem_addr, 32'h8000_2000);
        tick();
        tick();
        chk("t3_ddok", 32'(data_cache_dok), 1);
        chk("t3_idok0", 32'(inst_cache_dok), 0);
        chk("t3_drdata", data_cache_rdata, mem_word(32'h8000_2000));
        dir_data_req = 0;
        tick();
        chk("t3_idle_req", 32'(mem_req), 0);
        chk("t3_ddok_once", 32'(data_cache_dok), 0);
        tick();
        chk("t3_inst_req", 32'(mem_req), 1);
        chk("t3_inst_addr", mem_addr, 32'hBFC0_0010);
        tick();
        tick();
        chk("t3_idok", 32'(inst_cache_dok), 1);
        chk("t3_ddok_none", 32'(data_cache_dok), 0);
        chk("t3_irdata", inst_cache_rdata, mem_word(32'hBFC0_0010));
        dir_inst_req = 0;
        tick();
        chk("t3_idok_once", 32'(inst_cache_dok), 0);

        // Wait states: accept after 3 cycles, data after 4 more.
        cfg_aw = 3; cfg_dw = 4;
        dir_data_wr = 1; dir_data_addr = 32'h8000_1004;
        dir_data_wdata = 32'h1234_5678; dir_data_wstrb = 4'h3; dir_data_req = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t4_req_held", 32'(mem_req), 1);
            chk("t4_addr_held", mem_addr, 32'h8000_1004);
            chk("t4_wdata_held", mem_wdata, 32'h1234_5678);
            chk("t4_wstrb_held", 32'(mem_wstrb), 32'h3);
        end
        for (int i = 5; i <= 9; i++) begin
            tick();
            chk("t4_req_low", 32'(mem_req), 0);
            chk("t4_dok_wait", 32'(data_cache_dok), 0);
        end
        tick();
        chk("t4_dok", 32'(data_cache_dok), 1);
        dir_data_req = 0;
        tick();
        chk("t4_dok_once", 32'(data_cache_dok), 0);

        // Reset during the data phase abandons the transaction.
        cfg_aw = 0; cfg_dw = 6;
        dir_inst_addr = 32'hBFC0_0020; dir_inst_req = 1;
        tick();
        tick();
        dir_inst_req = 0;
        reset = 1;
        tick();
        chk("t5_rst_req", 32'(mem_req), 0);
        chk("t5_rst_idok", 32'(inst_cache_dok), 0);
        chk("t5_rst_rbuf", inst_cache_rdata, 0);
        reset = 0; cfg_dw = 0; inj_data_ok = 1;
        tick();
        inj_data_ok = 0;
        chk("t5_late_idok", 32'(inst_cache_dok), 0);
        tick();
        chk("t5_late_idok2", 32'(inst_cache_dok), 0);
        chk("t5_late_rbuf", inst_cache_rdata, 0);
        dir_data_wr = 0; dir_data_addr = 32'h8000_3000; dir_data_wstrb = 0; dir_data_req = 1;
        tick();
        chk("t5_new_req", 32'(mem_req), 1);
        tick();
        tick();
        chk("t5_new_dok", 32'(data_cache_dok), 1);
        chk("t5_new_rdata", data_cache_rdata, mem_word(32'h8000_3000));
        dir_data_req = 0;
        tick();

        // Flush: instruction request dropped while in the address phase.
        cfg_aw = 2; cfg_dw = 0;
        dir_inst_addr = 32'hBFC0_0030; dir_inst_req = 1;
        tick();
        chk("t6_req", 32'(mem_req), 1);
        dir_inst_req = 0;
        tick();
        chk("t6_req_hold2", 32'(mem_req), 1);
        tick();
        chk("t6_req_hold3", 32'(mem_req), 1);
        chk("t6_addr_hold", mem_addr, 32'hBFC0_0030);
        tick();
        chk("t6_req_low", 32'(mem_req), 0);
        tick();
        chk("t6_dok", 32'(inst_cache_dok), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_rereq", 32'(mem_req), 0);
            chk("t6_dok_once", 32'(inst_cache_dok), 0);
        end

        // Randomized traffic with random waits, stray strobes and resets.
        rand_waits = 1; rand_mode = 1;
        dok_start = n_dok;
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 0; rand_mode = 0;
        repeat (20) tick();
        chk("rand_progress", 32'((n_dok - dok_start) > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
